// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: one committed-store port and one load port share a
// single-outstanding memory interface, with bounded load starvation and flush kill.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_wmask,
  input  logic [31:0] st_wdata,
  output logic        st_done,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_rmask,
  output logic        ld_done,
  output logic [31:0] ld_rdata,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
);

  typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT, LD_DRAIN} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             ld_starved;
  logic             grant_st;
  logic             grant_ld;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= LIMIT) ? LIMIT : c + CNT_W'(1);
  endfunction

  // Grant decision: stores first unless a live load has waited out the limit.
  assign ld_starved = ld_req && !flush && (starve_cnt == LIMIT);
  assign grant_st   = (state == IDLE) && st_req && !ld_starved;
  assign grant_ld   = (state == IDLE) && ld_req && !flush && !grant_st;

  // Completion is reported in the response cycle itself.
  assign st_done  = (state == ST_WAIT) && dmem_resp;
  assign ld_done  = (state == LD_WAIT) && dmem_resp && !flush;
  assign ld_rdata = ld_done ? dmem_rdata : '0;

  // Request register stage: dmem_* hold a request for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      dmem_addr  <= '0;
      dmem_rmask <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
    end else begin
      dmem_addr  <= '0;
      dmem_rmask <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
      case (state)
        IDLE: begin
          if (grant_st) begin
            state      <= ST_WAIT;
            dmem_addr  <= st_addr;
            dmem_wmask <= st_wmask;
            dmem_wdata <= st_wdata;
            starve_cnt <= ld_req ? sat_inc(starve_cnt) : '0;
          end else if (grant_ld) begin
            state      <= LD_WAIT;
            dmem_addr  <= ld_addr;
            dmem_rmask <= ld_rmask;
            starve_cnt <= '0;
          end
        end
        LD_WAIT: begin
          if (dmem_resp)  state <= IDLE;
          else if (flush) state <= LD_DRAIN;
        end
        ST_WAIT: begin
          if (dmem_resp) state <= IDLE;
        end
        LD_DRAIN: begin
          if (dmem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and constrained-random bench for dmem_arbiter.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        st_req;
  logic [31:0] st_addr;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata;
  logic        st_done;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [3:0]  ld_rmask;
  logic        ld_done;
  logic [31:0] ld_rdata;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .st_req(st_req), .st_addr(st_addr), .st_wmask(st_wmask), .st_wdata(st_wdata),
    .st_done(st_done),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_rmask(ld_rmask),
    .ld_done(ld_done), .ld_rdata(ld_rdata),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  dmem_addr, 32'h0);
    chk({tag, "_rmask"}, 32'(dmem_rmask), 32'h0);
    chk({tag, "_wmask"}, 32'(dmem_wmask), 32'h0);
    chk({tag, "_wdata"}, dmem_wdata, 32'h0);
    chk({tag, "_stdone"}, 32'(st_done), 32'h0);
    chk({tag, "_lddone"}, 32'(ld_done), 32'h0);
    chk({tag, "_rdata"}, ld_rdata, 32'h0);
  endtask

  initial begin
    int sd, ldn, viol, grants, kills, dones, delay;
    int sd_at [2];
    logic busy, kind_ld, killed, first_st;
    logic [31:0] exp_rd;

    rst = 1'b1; flush = 1'b0;
    st_req = 1'b0; st_addr = '0; st_wmask = '0; st_wdata = '0;
    ld_req = 1'b0; ld_addr = '0; ld_rmask = '0;
    dmem_rdata = '0; dmem_resp = 1'b0;

    // Reset state
    tick();
    chk_all_zero("reset");
    tick();
    rst = 1'b0;

    // Load alone, response three cycles after the request is driven
    tick();
    ld_req = 1'b1; ld_addr = 32'h100; ld_rmask = 4'hF;
    settle();
    chk("ld_grant_cycle_rmask", 32'(dmem_rmask), 32'h0);
    tick();
    chk("ld_req_rmask", 32'(dmem_rmask), 32'hF);
    chk("ld_req_addr", dmem_addr, 32'h100);
    chk("ld_req_wmask", 32'(dmem_wmask), 32'h0);
    tick();
    chk("ld_req_one_cycle", 32'(dmem_rmask), 32'h0);
    chk("ld_no_early_done", 32'(ld_done), 32'h0);
    tick();
    tick();
    dmem_resp = 1'b1; dmem_rdata = 32'hDEADBEEF;
    settle();
    chk("ld_done", 32'(ld_done), 32'h1);
    chk("ld_rdata", ld_rdata, 32'hDEADBEEF);
    tick();
    ld_req = 1'b0; dmem_resp = 1'b0;
    settle();
    chk("ld_done_pulse", 32'(ld_done), 32'h0);
    chk("ld_rdata_zero", ld_rdata, 32'h0);

    // Contention: two rounds of four stores followed by the starved load
    st_req = 1'b1; st_addr = 32'h200; st_wmask = 4'h3; st_wdata = 32'h11223344;
    ld_req = 1'b1; ld_addr = 32'h300; ld_rmask = 4'hC;
    sd = 0; ldn = 0; viol = 0; first_st = 1'b1;
    sd_at[0] = -1; sd_at[1] = -1;
    for (int c = 0; c < 60 && ldn < 2; c++) begin
      tick();
      if (dmem_wmask != 0 && dmem_rmask != 0) viol++;
      if (first_st && dmem_wmask != 0) begin
        first_st = 1'b0;
        chk("st_req_addr", dmem_addr, 32'h200);
        chk("st_req_wmask", 32'(dmem_wmask), 32'h3);
        chk("st_req_wdata", dmem_wdata, 32'h11223344);
      end
      dmem_resp = (dmem_wmask != 0) || (dmem_rmask != 0);
      exp_rd = 32'hCAFE0000 + 32'(c);
      dmem_rdata = exp_rd;
      settle();
      if (st_done) sd++;
      if (ld_done) begin
        chk("contention_rdata", ld_rdata, exp_rd);
        sd_at[ldn] = sd;
        ldn++;
      end
    end
    tick();
    st_req = 1'b0; ld_req = 1'b0; dmem_resp = 1'b0;
    chk("contention_loads", 32'(ldn), 32'd2);
    chk("contention_round1_stores", 32'(sd_at[0]), 32'd4);
    chk("contention_round2_stores", 32'(sd_at[1]), 32'd8);
    chk("contention_mask_excl", 32'(viol), 32'd0);

    // No load grant while flush is high
    tick();
    ld_req = 1'b1; ld_addr = 32'h400; ld_rmask = 4'h1; flush = 1'b1;
    tick();
    chk("flush_blocks_grant", 32'(dmem_rmask), 32'h0);
    flush = 1'b0;

    // Flush one cycle before the response: drained, no ld_done
    tick();
    chk("flight_req_rmask", 32'(dmem_rmask), 32'h1);
    tick();
    flush = 1'b1;
    settle();
    chk("flight_flush_nodone", 32'(ld_done), 32'h0);
    tick();
    flush = 1'b0; ld_req = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'h12345678;
    settle();
    chk("drain_resp_nodone", 32'(ld_done), 32'h0);
    chk("drain_rdata_zero", ld_rdata, 32'h0);
    tick();
    dmem_resp = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h500; ld_rmask = 4'hF;
    tick();
    chk("after_drain_grant", 32'(dmem_rmask), 32'hF);
    chk("after_drain_addr", dmem_addr, 32'h500);
    dmem_resp = 1'b1; dmem_rdata = 32'h0BADF00D;
    settle();
    chk("same_cycle_resp_done", 32'(ld_done), 32'h1);
    chk("same_cycle_resp_rdata", ld_rdata, 32'h0BADF00D);
    tick();
    ld_req = 1'b0; dmem_resp = 1'b0;

    // Flush together with response; then store under flush still completes
    ld_req = 1'b1; ld_addr = 32'h540; ld_rmask = 4'h6;
    tick();
    chk("fr_req_rmask", 32'(dmem_rmask), 32'h6);
    flush = 1'b1; dmem_resp = 1'b1;
    settle();
    chk("flush_resp_nodone", 32'(ld_done), 32'h0);
    tick();
    flush = 1'b0; dmem_resp = 1'b0; ld_req = 1'b0;
    st_req = 1'b1; st_addr = 32'h580; st_wmask = 4'h9; st_wdata = 32'h55AA55AA;
    tick();
    chk("st_flush_wmask", 32'(dmem_wmask), 32'h9);
    chk("st_flush_rmask", 32'(dmem_rmask), 32'h0);
    flush = 1'b1; dmem_resp = 1'b1;
    settle();
    chk("st_flush_done", 32'(st_done), 32'h1);
    tick();
    flush = 1'b0; dmem_resp = 1'b0; st_req = 1'b0;
    settle();
    chk("st_flush_pulse", 32'(st_done), 32'h0);

    // Reset in ST_WAIT, late response ignored, first grant right after release
    st_req = 1'b1; st_addr = 32'h600; st_wmask = 4'hF; st_wdata = 32'hA5A5A5A5;
    tick();
    chk("rst_op_wmask", 32'(dmem_wmask), 32'hF);
    rst = 1'b1; st_req = 1'b0;
    settle();
    chk_all_zero("rst_async");
    tick();
    chk_all_zero("rst_held");
    rst = 1'b0; dmem_resp = 1'b1;
    st_req = 1'b1; st_addr = 32'h700; st_wmask = 4'h5; st_wdata = 32'h01020304;
    settle();
    chk("late_resp_ignored", 32'(st_done), 32'h0);
    tick();
    chk("first_grant_wmask", 32'(dmem_wmask), 32'h5);
    chk("first_grant_addr", dmem_addr, 32'h700);
    settle();
    chk("first_grant_done", 32'(st_done), 32'h1);
    tick();
    st_req = 1'b0; dmem_resp = 1'b0;

    // Random traffic with a one-outstanding memory model
    busy = 1'b0; kind_ld = 1'b0; killed = 1'b0; delay = 0;
    grants = 0; kills = 0; dones = 0; viol = 0;
    for (int c = 0; c < 320; c++) begin
      tick();
      if (c < 290) begin
        if (!st_req && $urandom_range(0, 3) == 0) begin
          st_req = 1'b1; st_addr = $urandom & 32'hFFFF_FFFC;
          st_wmask = 4'($urandom_range(1, 15)); st_wdata = $urandom;
        end
        if (!ld_req && $urandom_range(0, 2) == 0) begin
          ld_req = 1'b1; ld_addr = $urandom & 32'hFFFF_FFFC;
          ld_rmask = 4'($urandom_range(1, 15));
        end
        flush = ($urandom_range(0, 7) == 0);
      end else begin
        flush = 1'b0;
      end
      if (dmem_rmask != 0 || dmem_wmask != 0) begin
        grants++;
        if (dmem_rmask != 0 && dmem_wmask != 0) viol++;
        busy = 1'b1; kind_ld = (dmem_rmask != 0); killed = 1'b0;
        delay = $urandom_range(0, 3);
      end
      dmem_resp = 1'b0;
      if (busy) begin
        if (kind_ld && flush) killed = 1'b1;
        if (delay == 0) begin
          dmem_resp = 1'b1; exp_rd = $urandom; dmem_rdata = exp_rd;
        end else begin
          delay--;
        end
      end
      settle();
      if (dmem_resp) begin
        chk("rand_st_done", 32'(st_done), 32'(!kind_ld));
        chk("rand_ld_done", 32'(ld_done), 32'(kind_ld && !killed));
        if (kind_ld && !killed) chk("rand_rdata", ld_rdata, exp_rd);
        if (kind_ld && killed) kills++;
        busy = 1'b0;
      end
      if (st_done) dones++;
      if (ld_done) dones++;
      if (st_done) st_req = 1'b0;
      if (ld_done || flush) ld_req = 1'b0;
    end
    tick();
    dmem_resp = 1'b0;
    chk("rand_drained", 32'(busy), 32'h0);
    chk("rand_mask_excl", 32'(viol), 32'd0);
    chk("rand_done_count", 32'(dones), 32'(grants - kills));
    chk("rand_traffic", 32'(grants > 20), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
